uart_bram_tx_ctrl: RTL and testbench

//  Sequencer that streams a block of bytes from the on-chip BRAM out through the UART transmitter.
//  - Accepts a command: start address, byte count, baud select.
//  - Reads each byte from BRAM, presents it to the transmitter and holds tx_send_en until tx_done.
//  - Sits between the command/control logic and the uart_tx + BRAM read port.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bram_tx_ctrl_if.sv | 14 +
 rtl/uart_rd_lat_pipe.sv | 24 ++
 rtl/uart_bram_tx_ctrl.sv | 106 ++++++++++
 tb/tb_uart_bram_tx_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and baud select codes for the BRAM-to-UART sequencer
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_GAP  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    // Unused select codes fall back to the slowest, always-supported rate.
    function automatic logic [2:0] baud_map(input logic [2:0] sel);
        return (sel > BAUD_115200) ? BAUD_9600 : sel;
    endfunction

endpackage

// File: rtl/uart_bram_tx_ctrl_if.sv
// rtl/uart_bram_tx_ctrl_if.sv - command handshake bundle for the BRAM-to-UART sequencer
interface uart_bram_tx_ctrl_if #(
    parameter int AW = 10,
    parameter int LW = 11
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [2:0]    cmd_baud;

    modport master (output cmd_valid, cmd_addr, cmd_len, cmd_baud, input cmd_ready);
    modport slave  (input cmd_valid, cmd_addr, cmd_len, cmd_baud, output cmd_ready);
endinterface

// File: rtl/uart_rd_lat_pipe.sv
// rtl/uart_rd_lat_pipe.sv - valid shift register tracking BRAM read latency
module uart_rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_en,
    output logic data_valid,
    output logic data_ready
);
    logic [RD_LAT:0] vld_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[RD_LAT-1:0], rd_en};
        end
    end

    // data_valid: bram_dout is valid now; data_ready: the byte sits in tx_data.
    assign data_valid = vld_sr[RD_LAT-1];
    assign data_ready = vld_sr[RD_LAT];
endmodule

// File: rtl/uart_bram_tx_ctrl.sv
// rtl/uart_bram_tx_ctrl.sv - streams a block of BRAM bytes through the UART transmitter
module uart_bram_tx_ctrl
    import uart_pkg::*;
#(
    parameter int AW     = 10,
    parameter int LW     = 11,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_bram_tx_ctrl_if.slave  cmd,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [LW-1:0]       sent_cnt,
    output logic                bram_en,
    output logic [AW-1:0]       bram_addr,
    input  logic [7:0]          bram_dout,
    output logic [2:0]          tx_baud_set,
    output logic [7:0]          tx_data,
    output logic                tx_send_en,
    input  logic                tx_done
);
    state_t        state, state_nxt;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] remaining;
    logic          abort_pend;
    logic          abort_hit;
    logic          accept;
    logic          data_valid;
    logic          data_ready;

    assign accept    = cmd.cmd_valid && cmd.cmd_ready;
    assign abort_hit = abort || abort_pend;

    uart_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_rd_lat_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (bram_en),
        .data_valid (data_valid),
        .data_ready (data_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort is never taken in SEND: dropping send_en mid-frame would strand the line low.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (cmd.cmd_len == '0) ? ST_FIN : ST_RD;
            ST_RD:   state_nxt = abort_hit ? ST_FIN : ST_WAIT;
            ST_WAIT: begin
                if (abort_hit)       state_nxt = ST_FIN;
                else if (data_ready) state_nxt = ST_SEND;
            end
            ST_SEND: if (tx_done) state_nxt = ST_GAP;
            ST_GAP:  state_nxt = (remaining != '0 && !abort_hit) ? ST_RD : ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr    <= '0;
            remaining   <= '0;
            sent_cnt    <= '0;
            tx_baud_set <= BAUD_9600;
            tx_data     <= 8'h00;
            abort_pend  <= 1'b0;
        end else begin
            if (accept) begin
                cur_addr    <= cmd.cmd_addr;
                remaining   <= cmd.cmd_len;
                sent_cnt    <= '0;
                tx_baud_set <= baud_map(cmd.cmd_baud);
            end
            if (state == ST_WAIT && data_valid) begin
                tx_data <= bram_dout;
            end
            if (state == ST_SEND && tx_done) begin
                sent_cnt  <= sent_cnt + 1'b1;
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (state == ST_IDLE || state == ST_FIN) begin
                abort_pend <= 1'b0;
            end else if (abort) begin
                abort_pend <= 1'b1;
            end
        end
    end

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE) && (state != ST_FIN);
    assign done          = (state == ST_FIN);
    assign bram_en       = (state == ST_RD);
    assign bram_addr     = cur_addr;
    assign tx_send_en    = (state == ST_SEND);
endmodule

// File: tb/tb_uart_bram_tx_ctrl.sv
// tb/tb_uart_bram_tx_ctrl.sv - self-checking bench for uart_bram_tx_ctrl at RD_LAT 1 and 2
module tb_uart_bram_tx_ctrl;
    import uart_pkg::*;

    localparam int AW = 10;
    localparam int LW = 11;
    localparam int N  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int            sel;
    logic          clr_req;
    logic          cmd_valid;
    logic          abort_in;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [2:0]    cmd_baud;

    logic          cmd_ready_w [N];
    logic          busy_w      [N];
    logic          done_w      [N];
    logic          bram_en_w   [N];
    logic          send_w      [N];
    logic [LW-1:0] sent_w      [N];
    logic [AW-1:0] addr_w      [N];
    logic [2:0]    baud_w      [N];
    logic [7:0]    data_w      [N];
    logic [7:0]    bram_dout_w [N];

    logic [7:0]    mem [0:1023];
    logic [7:0]    d1 [N];
    logic [7:0]    d2 [N];
    logic          tx_done_r [N];
    logic          line [N];
    logic          dn [N];
    logic [7:0]    cap [N];
    logic [7:0]    rx_sh [N];
    logic [7:0]    rx_buf [N][16];
    logic [AW-1:0] en_log [N][16];
    int            cnt [N];
    int            gap [N];
    int            done_cnt [N];
    int            en_cnt [N];
    int            frame_cnt [N];
    int            rx_n [N];
    int            frame_err [N];
    int            gap_bad [N];

    int n_pass  = 0;
    int n_total = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_bram_tx_ctrl_if #(.AW(AW), .LW(LW)) cmd_if ();
        assign cmd_if.cmd_valid = cmd_valid && (sel == g);
        assign cmd_if.cmd_addr  = cmd_addr;
        assign cmd_if.cmd_len   = cmd_len;
        assign cmd_if.cmd_baud  = cmd_baud;
        assign cmd_ready_w[g]   = cmd_if.cmd_ready;
        assign bram_dout_w[g]   = (g == 0) ? d1[g] : d2[g];

        uart_bram_tx_ctrl #(.AW(AW), .LW(LW), .RD_LAT(g + 1)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .cmd         (cmd_if),
            .abort       (abort_in && (sel == g)),
            .busy        (busy_w[g]),
            .done        (done_w[g]),
            .sent_cnt    (sent_w[g]),
            .bram_en     (bram_en_w[g]),
            .bram_addr   (addr_w[g]),
            .bram_dout   (bram_dout_w[g]),
            .tx_baud_set (baud_w[g]),
            .tx_data     (data_w[g]),
            .tx_send_en  (send_w[g]),
            .tx_done     (tx_done_r[g])
        );
    end

    // BRAM with latency 1/2 (junk when not enabled) plus an 8N1 transmitter and line decoder.
    always @(posedge clk or negedge rst_n) begin : model
        int p, b;
        for (int g = 0; g < N; g++) begin
            if (!rst_n) begin
                d1[g] <= 8'h00; d2[g] <= 8'h00; tx_done_r[g] <= 1'b0; line[g] <= 1'b1;
                dn[g] <= 1'b0; cap[g] <= 8'h00; rx_sh[g] <= 8'h00; cnt[g] <= 0; gap[g] <= 0;
                done_cnt[g] <= 0; en_cnt[g] <= 0; frame_cnt[g] <= 0; rx_n[g] <= 0;
                frame_err[g] <= 0; gap_bad[g] <= 0;
            end else begin
                d1[g] <= bram_en_w[g] ? mem[addr_w[g]] : ~mem[addr_w[g]];
                d2[g] <= d1[g];
                tx_done_r[g] <= 1'b0;
                p = (baud_w[g] <= 3'd4) ? 12 - 2 * int'(baud_w[g]) : 12;
                b = cnt[g] / p;
                if (done_w[g]) done_cnt[g] <= done_cnt[g] + 1;
                if (bram_en_w[g]) begin
                    if (en_cnt[g] < 16) en_log[g][en_cnt[g]] <= addr_w[g];
                    en_cnt[g] <= en_cnt[g] + 1;
                end
                if (!send_w[g]) begin
                    if (cnt[g] != 0 && (!dn[g] || line[g] !== 1'b1)) frame_err[g] <= frame_err[g] + 1;
                    cnt[g] <= 0;
                    dn[g]  <= 1'b0;
                    gap[g] <= gap[g] + 1;
                end else begin
                    cnt[g] <= cnt[g] + 1;
                    if (cnt[g] == 0) begin
                        cap[g] <= data_w[g];
                        frame_cnt[g] <= frame_cnt[g] + 1;
                        if (frame_cnt[g] != 0 && gap[g] != g + 4) gap_bad[g] <= gap_bad[g] + 1;
                        gap[g] <= 0;
                    end else if (data_w[g] !== cap[g]) begin
                        frame_err[g] <= frame_err[g] + 1;
                    end
                    if (cnt[g] % p == 0)
                        line[g] <= (b == 0) ? 1'b0 : (b <= 8) ? cap[g][b-1] : 1'b1;
                    if (cnt[g] % p == p / 2) begin
                        if (b == 0 && line[g] !== 1'b0) frame_err[g] <= frame_err[g] + 1;
                        else if (b >= 1 && b <= 8) rx_sh[g][b-1] <= line[g];
                        else if (b == 9) begin
                            if (line[g] !== 1'b1) frame_err[g] <= frame_err[g] + 1;
                            if (rx_n[g] < 16) rx_buf[g][rx_n[g]] <= rx_sh[g];
                            rx_n[g] <= rx_n[g] + 1;
                            tx_done_r[g] <= 1'b1;
                            dn[g] <= 1'b1;
                        end
                    end
                end
                if (clr_req) begin
                    done_cnt[g] <= 0; en_cnt[g] <= 0; frame_cnt[g] <= 0; rx_n[g] <= 0;
                    frame_err[g] <= 0; gap_bad[g] <= 0;
                end
            end
        end
    end

    function automatic int ref_baud(input int b);
        return (b > 4) ? 0 : b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_reset(input int g, input string tag);
        check({tag, " ctl"}, {cmd_ready_w[g], busy_w[g], done_w[g], bram_en_w[g], send_w[g]}, 5'b10000);
        check({tag, " sent_cnt"}, sent_w[g], 0);
        check({tag, " bram_addr"}, addr_w[g], 0);
        check({tag, " baud/data"}, {baud_w[g], data_w[g]}, 0);
    endtask

    task automatic run_cmd(input int g, input int addr, input int len, input int baud, input int abrt,
                           input bit dup, input int exp_sent, input int exp_baud, input string tag);
        int lat, errs;
        bit abort_sent;
        abort_sent = 0;
        errs = 0;
        sel = g;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        cmd_addr  = addr[AW-1:0];
        cmd_len   = len[LW-1:0];
        cmd_baud  = baud[2:0];
        cmd_valid = 1'b1;
        check({tag, " ready"}, cmd_ready_w[g], 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done_w[g] && lat < 6000) begin
            abort_in  = 1'b0;
            cmd_valid = 1'b0;
            if (abrt > 0 && frame_cnt[g] == abrt && send_w[g] && !abort_sent) begin
                abort_in = 1'b1;
                abort_sent = 1;
            end
            if (dup && lat == 4) begin
                cmd_valid = 1'b1;
                cmd_addr  = ~cmd_addr;
                cmd_len   = 1;
            end
            @(negedge clk);
            lat++;
        end
        abort_in  = 1'b0;
        cmd_valid = 1'b0;
        if (len == 0) check({tag, " done latency"}, lat, 1);
        repeat (3) @(negedge clk);
        check({tag, " done pulses"}, done_cnt[g], 1);
        check({tag, " sent_cnt"}, sent_w[g], exp_sent);
        check({tag, " rx bytes"}, rx_n[g], exp_sent);
        check({tag, " bram_en pulses"}, en_cnt[g], exp_sent);
        for (int i = 0; i < rx_n[g] && i < 16; i++)
            if (rx_buf[g][i] !== mem[(addr + i) % 1024]) errs++;
        check({tag, " byte errors"}, errs, 0);
        check({tag, " frame errors"}, frame_err[g], 0);
        check({tag, " gap errors"}, gap_bad[g], 0);
        check({tag, " baud_set"}, baud_w[g], exp_baud);
        check({tag, " idle"}, {busy_w[g], cmd_ready_w[g]}, 2'b01);
    endtask

    typedef struct {
        int addr; int len; int baud; int abrt; bit dup; int exp_sent; int exp_baud;
    } vec_t;

    initial begin
        vec_t tab [6];
        int t;
        tab[0] = '{32'h010, 3, 4, -1, 1'b0, 3, 4};
        tab[1] = '{32'h000, 0, 2, -1, 1'b0, 0, 2};
        tab[2] = '{32'h3FF, 2, 1, -1, 1'b0, 2, 1};
        tab[3] = '{32'h020, 5, 3,  2, 1'b0, 2, 3};
        tab[4] = '{32'h040, 2, 6, -1, 1'b1, 2, 0};
        tab[5] = '{32'h3FE, 4, 7, -1, 1'b0, 4, 0};

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[16] = 8'hA5; mem[17] = 8'h3C; mem[18] = 8'hFF;
        sel = 0; clr_req = 0; cmd_valid = 0; abort_in = 0;
        cmd_addr = '0; cmd_len = '0; cmd_baud = '0;

        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) check_reset(g, $sformatf("reset%0d", g));
        rst_n = 1'b1;
        @(negedge clk);

        for (int g = 0; g < N; g++) begin
            for (int r = 0; r < 6; r++) begin
                run_cmd(g, tab[r].addr, tab[r].len, tab[r].baud, tab[r].abrt, tab[r].dup,
                        tab[r].exp_sent, tab[r].exp_baud, $sformatf("tab%0d.%0d", g, r));
                if (r == 2) begin
                    check($sformatf("wrap%0d first", g), en_log[g][0], 10'h3FF);
                    check($sformatf("wrap%0d second", g), en_log[g][1], 10'h000);
                end
            end
        end

        for (int g = 0; g < N; g++) begin
            sel = g;
            clr_req = 1'b1;
            @(negedge clk);
            clr_req = 1'b0;
            cmd_addr = 10'h100; cmd_len = 4; cmd_baud = 3'd4; cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            t = 0;
            while (!(frame_cnt[g] == 1 && send_w[g]) && t < 2000) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("rst%0d reach send", g), t < 2000, 1);
            repeat (5) @(negedge clk);
            #2 rst_n = 1'b0;
            #1 check_reset(g, $sformatf("midrst%0d", g));
            @(negedge clk);
            rst_n = 1'b1;
            run_cmd(g, 32'h200, 3, 2, -1, 1'b0, 3, 2, $sformatf("postrst%0d", g));
        end

        for (int g = 0; g < N; g++) begin
            for (int k = 0; k < 8; k++) begin
                int a, l, bd;
                a  = $urandom_range(0, 1023);
                l  = $urandom_range(0, 6);
                bd = $urandom_range(0, 7);
                run_cmd(g, a, l, bd, -1, 1'b0, l, ref_baud(bd), $sformatf("rnd%0d.%0d", g, k));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
